// File: rtl/bp_pkg.sv
// Shared encodings for the fetch-stage branch predictor: control-flow types
// and 2-bit direction counter constants.
package bp_pkg;

    typedef enum logic [1:0] {
        BP_BR   = 2'd0,
        BP_JAL  = 2'd1,
        BP_JALR = 2'd2,
        BP_RET  = 2'd3
    } bp_type_e;

    localparam logic [1:0] CTR_MIN  = 2'b00;
    localparam logic [1:0] CTR_INIT = 2'b10;
    localparam logic [1:0] CTR_MAX  = 2'b11;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != CTR_MAX)
            res = ctr + 2'd1;
        else if (!taken && ctr != CTR_MIN)
            res = ctr - 2'd1;
        return res;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and EX/MEM-side training signals of the branch predictor.
// master = pipeline, slave = predictor.
interface branch_predictor_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  lookup_valid_i;
    logic [DATA_WIDTH-1:0] pc_i;
    logic                  stall_i;
    logic                  flush_i;
    logic                  pred_taken_o;
    logic [DATA_WIDTH-1:0] pred_pc_o;
    logic                  upd_valid_i;
    logic [DATA_WIDTH-1:0] upd_pc_i;
    logic [1:0]            upd_type_i;
    logic                  upd_call_i;
    logic                  upd_taken_i;
    logic [DATA_WIDTH-1:0] upd_target_i;

    modport master (
        output lookup_valid_i, pc_i, stall_i, flush_i,
        output upd_valid_i, upd_pc_i, upd_type_i, upd_call_i, upd_taken_i, upd_target_i,
        input  pred_taken_o, pred_pc_o
    );

    modport slave (
        input  lookup_valid_i, pc_i, stall_i, flush_i,
        input  upd_valid_i, upd_pc_i, upd_type_i, upd_call_i, upd_taken_i, upd_target_i,
        output pred_taken_o, pred_pc_o
    );
endinterface

// File: rtl/bp_ras.sv
// Return-address stack with a speculative pointer/count driven from fetch and a
// committed copy driven from resolved calls/returns, used to recover on flush.
module bp_ras #(
    parameter int RAS_DEPTH  = 8,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    input  logic                  restore_i,
    input  logic                  commit_push_i,
    input  logic                  commit_pop_i,
    output logic [DATA_WIDTH-1:0] top_o,
    output logic                  empty_o
);
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [DATA_WIDTH-1:0] stack_q [RAS_DEPTH];
    logic [PW-1:0]         ptr_q, ptr_d, cptr_q, cptr_d;
    logic [CW-1:0]         cnt_q, cnt_d, ccnt_q, ccnt_d;
    logic                  push_en;

    assign top_o   = stack_q[ptr_q - PW'(1)];
    assign empty_o = (cnt_q == '0);

    always_comb begin
        cptr_d  = cptr_q;
        ccnt_d  = ccnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        push_en = 1'b0;
        if (commit_push_i && !commit_pop_i) begin
            cptr_d = cptr_q + PW'(1);
            if (ccnt_q != FULL)
                ccnt_d = ccnt_q + CW'(1);
        end else if (commit_pop_i && !commit_push_i && ccnt_q != '0) begin
            cptr_d = cptr_q - PW'(1);
            ccnt_d = ccnt_q - CW'(1);
        end
        // Restore picks up any resolved call/return landing in the flush cycle.
        if (restore_i) begin
            ptr_d = cptr_d;
            cnt_d = ccnt_d;
        end else if (push_i) begin
            push_en = 1'b1;
            ptr_d   = ptr_q + PW'(1);
            if (cnt_q != FULL)
                cnt_d = cnt_q + CW'(1);
        end else if (pop_i && cnt_q != '0) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            cptr_q <= '0;
            ccnt_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            cptr_q <= cptr_d;
            ccnt_q <= ccnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push_en)
            stack_q[ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, zero-latency lookup.
// Define BP_RAS_EN to add a return-address stack for RET prediction.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ENTRIES    = 64,
    parameter int TAG_WIDTH  = 10,
    parameter int RAS_DEPTH  = 8
) (
    input logic               clk_i,
    input logic               rst_i,
    branch_predictor_if.slave bp
);
    localparam int IDXW = $clog2(ENTRIES);
    localparam int TLO  = IDXW + 2;
    localparam int THI  = IDXW + TAG_WIDTH + 1;

    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_WIDTH-1:0]  tag_q    [ENTRIES];
    logic [DATA_WIDTH-1:0] target_q [ENTRIES];
    bp_type_e              type_q   [ENTRIES];
    logic [ENTRIES-1:0]    call_q;
    logic [1:0]            ctr_q    [ENTRIES];

    logic [IDXW-1:0]       l_idx, u_idx;
    logic                  l_hit, l_taken, u_hit;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  wr_en, wr_meta;
    logic [1:0]            ctr_d;

    assign l_idx    = bp.pc_i[IDXW+1:2];
    assign l_hit    = bp.lookup_valid_i && valid_q[l_idx] && (tag_q[l_idx] == bp.pc_i[THI:TLO]);
    assign l_taken  = l_hit && (type_q[l_idx] != BP_BR || ctr_q[l_idx][1]);
    assign pc_plus4 = bp.pc_i + DATA_WIDTH'(4);

`ifdef BP_RAS_EN
    logic [DATA_WIDTH-1:0] ras_top;
    logic                  ras_empty, l_ret;

    assign l_ret = l_hit && (type_q[l_idx] == BP_RET);

    bp_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ras (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (l_taken && call_q[l_idx] && !l_ret && !bp.stall_i),
        .push_data_i  (pc_plus4),
        .pop_i        (l_ret && !bp.stall_i),
        .restore_i    (bp.flush_i),
        .commit_push_i(bp.upd_valid_i && bp.upd_call_i && bp.upd_taken_i),
        .commit_pop_i (bp.upd_valid_i && (bp.upd_type_i == BP_RET)),
        .top_o        (ras_top),
        .empty_o      (ras_empty)
    );

    always_comb begin
        bp.pred_taken_o = l_taken;
        bp.pred_pc_o    = l_taken ? target_q[l_idx] : pc_plus4;
        if (l_ret && !ras_empty)
            bp.pred_pc_o = ras_top;
    end

    logic unused_bits;
    assign unused_bits = ^{bp.pc_i[1:0], bp.pc_i[DATA_WIDTH-1:THI+1],
                           bp.upd_pc_i[1:0], bp.upd_pc_i[DATA_WIDTH-1:THI+1]};
`else
    always_comb begin
        bp.pred_taken_o = l_taken;
        bp.pred_pc_o    = l_taken ? target_q[l_idx] : pc_plus4;
    end

    logic unused_bits;
    assign unused_bits = ^{bp.pc_i[1:0], bp.pc_i[DATA_WIDTH-1:THI+1],
                           bp.upd_pc_i[1:0], bp.upd_pc_i[DATA_WIDTH-1:THI+1],
                           bp.stall_i, bp.flush_i, call_q};
`endif

    assign u_idx = bp.upd_pc_i[IDXW+1:2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == bp.upd_pc_i[THI:TLO]);

    // Not-taken misses never allocate, so cold branches don't evict useful entries.
    always_comb begin
        wr_en   = 1'b0;
        wr_meta = 1'b0;
        ctr_d   = ctr_q[u_idx];
        if (bp.upd_valid_i) begin
            if (u_hit) begin
                wr_en   = 1'b1;
                wr_meta = bp.upd_taken_i;
                ctr_d   = ctr_next(ctr_q[u_idx], bp.upd_taken_i);
            end else if (bp.upd_taken_i) begin
                wr_en   = 1'b1;
                wr_meta = 1'b1;
                ctr_d   = CTR_INIT;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            valid_q <= '0;
        else if (wr_en && wr_meta)
            valid_q[u_idx] <= 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) begin
            ctr_q[u_idx] <= ctr_d;
            if (wr_meta) begin
                tag_q[u_idx]    <= bp.upd_pc_i[THI:TLO];
                target_q[u_idx] <= bp.upd_target_i;
                type_q[u_idx]   <= bp_type_e'(bp.upd_type_i);
                call_q[u_idx]   <= bp.upd_call_i;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor; RAS steps are compiled
// only when BP_RAS_EN is defined.
module tb_branch_predictor;
    import bp_pkg::*;

    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    branch_predictor_if #(.DATA_WIDTH(DW)) bp ();

    branch_predictor #(
        .DATA_WIDTH(DW),
        .ENTRIES   (64),
        .TAG_WIDTH (10),
        .RAS_DEPTH (8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bp   (bp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [63:0] pc, input logic et, input logic [63:0] epc);
        bp.lookup_valid_i = 1'b1;
        bp.pc_i           = pc;
        #1;
        check({tag, ".taken"}, 64'(bp.pred_taken_o), 64'(et));
        check({tag, ".pc"}, bp.pred_pc_o, epc);
        bp.lookup_valid_i = 1'b0;
    endtask

    task automatic upd(input logic [63:0] pc, input logic [1:0] typ, input logic call,
                       input logic taken, input logic [63:0] tgt);
        bp.upd_valid_i  = 1'b1;
        bp.upd_pc_i     = pc;
        bp.upd_type_i   = typ;
        bp.upd_call_i   = call;
        bp.upd_taken_i  = taken;
        bp.upd_target_i = tgt;
        @(posedge clk);
        #1;
        bp.upd_valid_i = 1'b0;
    endtask

    // Lookup that stays valid across a clock edge so RAS push/pop take effect.
    task automatic fetch(input string tag, input logic [63:0] pc, input logic et, input logic [63:0] epc);
        bp.lookup_valid_i = 1'b1;
        bp.pc_i           = pc;
        #1;
        check({tag, ".taken"}, 64'(bp.pred_taken_o), 64'(et));
        check({tag, ".pc"}, bp.pred_pc_o, epc);
        @(posedge clk);
        #1;
        bp.lookup_valid_i = 1'b0;
    endtask

    initial begin
        bp.lookup_valid_i = 1'b0;
        bp.pc_i           = '0;
        bp.stall_i        = 1'b0;
        bp.flush_i        = 1'b0;
        bp.upd_valid_i    = 1'b1;
        bp.upd_pc_i       = 64'h1000;
        bp.upd_type_i     = BP_BR;
        bp.upd_call_i     = 1'b0;
        bp.upd_taken_i    = 1'b1;
        bp.upd_target_i   = 64'h0F00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bp.upd_valid_i = 1'b0;

        // Update presented during reset must be discarded.
        look("reset", 64'h1000, 1'b0, 64'h1004);

        upd(64'h1000, BP_BR, 1'b0, 1'b1, 64'h0F00);
        look("alloc", 64'h1000, 1'b1, 64'h0F00);

        bp.lookup_valid_i = 1'b0;
        bp.pc_i           = 64'h1000;
        #1;
        check("novalid.taken", 64'(bp.pred_taken_o), 64'd0);
        check("novalid.pc", bp.pred_pc_o, 64'h1004);

        // Same index, other tag, not taken: ignored, no eviction.
        upd(64'h3000, BP_BR, 1'b0, 1'b0, 64'h0AAA);
        look("ntmiss", 64'h3000, 1'b0, 64'h3004);
        look("ntmiss_keep", 64'h1000, 1'b1, 64'h0F00);

        upd(64'h1000, BP_BR, 1'b0, 1'b0, 64'h0);
        look("ctr1", 64'h1000, 1'b0, 64'h1004);
        upd(64'h1000, BP_BR, 1'b0, 1'b0, 64'h0);
        look("ctr0", 64'h1000, 1'b0, 64'h1004);
        upd(64'h1000, BP_BR, 1'b0, 1'b0, 64'h0);
        look("ctr0_sat", 64'h1000, 1'b0, 64'h1004);
        upd(64'h1000, BP_BR, 1'b0, 1'b1, 64'h0F00);
        look("ctr0to1", 64'h1000, 1'b0, 64'h1004);
        upd(64'h1000, BP_BR, 1'b0, 1'b1, 64'h0F00);
        look("ctr2", 64'h1000, 1'b1, 64'h0F00);
        upd(64'h1000, BP_BR, 1'b0, 1'b1, 64'h0F00);
        look("ctr3", 64'h1000, 1'b1, 64'h0F00);
        upd(64'h1000, BP_BR, 1'b0, 1'b1, 64'h0F00);
        look("ctr3_sat", 64'h1000, 1'b1, 64'h0F00);
        upd(64'h1000, BP_BR, 1'b0, 1'b0, 64'h0);
        look("ctr3to2", 64'h1000, 1'b1, 64'h0F00);
        upd(64'h1000, BP_BR, 1'b0, 1'b0, 64'h0);
        look("ctr2to1", 64'h1000, 1'b0, 64'h1004);
        upd(64'h1000, BP_BR, 1'b0, 1'b1, 64'h0F00);
        look("retrain", 64'h1000, 1'b1, 64'h0F00);

        // Alias: 0x1000 + 4*64 shares the index, different tag.
        upd(64'h1100, BP_BR, 1'b0, 1'b1, 64'h2000);
        look("alias_new", 64'h1100, 1'b1, 64'h2000);
        look("alias_evict", 64'h1000, 1'b0, 64'h1004);

        upd(64'h2040, BP_JAL, 1'b0, 1'b1, 64'h5000);
        look("jal", 64'h2040, 1'b1, 64'h5000);
        upd(64'h2040, BP_JAL, 1'b0, 1'b1, 64'h6000);
        look("jal_retgt", 64'h2040, 1'b1, 64'h6000);

        // Same-cycle lookup and update of one index.
        bp.lookup_valid_i = 1'b1;
        bp.pc_i           = 64'h1000;
        bp.upd_valid_i    = 1'b1;
        bp.upd_pc_i       = 64'h1000;
        bp.upd_type_i     = BP_BR;
        bp.upd_call_i     = 1'b0;
        bp.upd_taken_i    = 1'b1;
        bp.upd_target_i   = 64'h0F00;
        #1;
        check("same_old.taken", 64'(bp.pred_taken_o), 64'd0);
        check("same_old.pc", bp.pred_pc_o, 64'h1004);
        @(posedge clk);
        #1;
        bp.upd_valid_i = 1'b0;
        check("same_new.taken", 64'(bp.pred_taken_o), 64'd1);
        check("same_new.pc", bp.pred_pc_o, 64'h0F00);
        bp.lookup_valid_i = 1'b0;

        look("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);

        bp.flush_i = 1'b1;
        upd(64'h2080, BP_JAL, 1'b0, 1'b1, 64'h7000);
        bp.flush_i = 1'b0;
        look("flush_upd", 64'h2080, 1'b1, 64'h7000);

`ifdef BP_RAS_EN
        upd(64'h0100, BP_JAL, 1'b1, 1'b1, 64'h0400);
        upd(64'h0480, BP_RET, 1'b0, 1'b1, 64'h0999);
        fetch("ras_call", 64'h0100, 1'b1, 64'h0400);
        fetch("ras_ret", 64'h0480, 1'b1, 64'h0104);
        fetch("ras_empty", 64'h0480, 1'b1, 64'h0999);

        fetch("ras_call2", 64'h0100, 1'b1, 64'h0400);
        bp.stall_i = 1'b1;
        fetch("ras_stall1", 64'h0480, 1'b1, 64'h0104);
        fetch("ras_stall2", 64'h0480, 1'b1, 64'h0104);
        bp.stall_i = 1'b0;

        for (int i = 0; i < 9; i++)
            fetch($sformatf("ras_nest%0d", i), 64'h0100, 1'b1, 64'h0400);
        look("ras_full_top", 64'h0480, 1'b1, 64'h0104);

        bp.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bp.flush_i = 1'b0;
        look("ras_restore", 64'h0480, 1'b1, 64'h0999);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
